// File: rtl/dtag_array_if.sv
// Bundle between the load/store pipeline and the data-cache tag store.
//   master : pipeline side; drives the stage-1/stage-2 addresses, the fill request and the
//            external-invalidation requests.
//   slave  : dtag_array; returns hit results, invalidation flow control and sweep status.
// When DTAG_PARITY_EN is defined the bundle also carries parity_err.
interface dtag_array_if #(
  parameter int unsigned WAYS = 4
);
  logic [31:0]     stage1_addr;
  logic            stage1_adv;
  logic            stage1_inv;
  logic [31:0]     stage2_addr;
  logic            update;
  logic [WAYS-1:0] update_way;
  logic [31:0]     inv_addr;
  logic            inv_valid;
  logic            inv_ready;
  logic            inv_pending;
  logic            init_done;
  logic            tag_hit;
  logic [WAYS-1:0] tag_hit_way;
`ifdef DTAG_PARITY_EN
  logic            parity_err;
`endif

  modport master (
    output stage1_addr, stage1_adv, stage1_inv, stage2_addr, update, update_way,
    output inv_addr, inv_valid,
    input  inv_ready, inv_pending, init_done, tag_hit, tag_hit_way
`ifdef DTAG_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  stage1_addr, stage1_adv, stage1_inv, stage2_addr, update, update_way,
    input  inv_addr, inv_valid,
    output inv_ready, inv_pending, init_done, tag_hit, tag_hit_way
`ifdef DTAG_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/dtag_array.sv
// Data-cache tag store: WAYS x LINES entries of {valid, tag}, two ports per way.
//   Port A : stage-1 registered read (stage1_adv), stage-2 compare, stage-1 invalidate.
//   Port B : post-reset clear sweep, miss fills (update) and a queued external-invalidation
//            engine (read line, compare, clear hitting ways).
// Ports:
//   clk         clock
//   rst         asynchronous active-low reset
//   bus         dtag_array_if.slave: stage1_addr/adv/inv, stage2_addr, update, update_way,
//               inv_addr/valid/ready, inv_pending, init_done, tag_hit, tag_hit_way
// Optional: define DTAG_PARITY_EN to add an even-parity bit per entry and bus.parity_err.
module dtag_array #(
  parameter int unsigned WAYS            = 4,
  parameter int unsigned LINES           = 64,
  parameter int unsigned TAG_W           = 20,
  parameter int unsigned SUB_LINE_ADDR_W = 2,
  parameter int unsigned INV_FIFO_DEPTH  = 4
) (
  input logic         clk,
  input logic         rst,
  dtag_array_if.slave bus
);

  localparam int unsigned LINE_W   = $clog2(LINES);
  localparam int unsigned LINE_LSB = 2 + SUB_LINE_ADDR_W;
  localparam int unsigned TAG_LSB  = LINE_LSB + LINE_W;
  localparam int unsigned PTR_W    = $clog2(INV_FIFO_DEPTH);
`ifdef DTAG_PARITY_EN
  localparam int unsigned ENT_W    = TAG_W + 2;
`else
  localparam int unsigned ENT_W    = TAG_W + 1;
`endif

  if (2 + SUB_LINE_ADDR_W + LINE_W + TAG_W > 32) begin : gen_addr_too_wide
    $error("dtag_array: line + tag fields do not fit in a 32-bit address");
  end

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [ENT_W-1:0]  entry_t;

  typedef enum logic [1:0] {StInit, StIdle, StInvRd, StInvWr} state_e;

  function automatic line_t line_of(input logic [31:0] addr);
    return addr[LINE_LSB +: LINE_W];
  endfunction

  function automatic tag_t tag_of(input logic [31:0] addr);
    return addr[TAG_LSB +: TAG_W];
  endfunction

  // Invalid entries are written as all-zero, which also carries correct even parity.
  function automatic entry_t live_entry(input tag_t tag);
`ifdef DTAG_PARITY_EN
    return {^{1'b1, tag}, 1'b1, tag};
`else
    return {1'b1, tag};
`endif
  endfunction

  // Storage and state
  entry_t            tag_mem [WAYS][LINES];
  state_e            state_q, state_d;
  line_t             sweep_q, sweep_d;
  logic              init_done_q, init_done_d;
  logic [31:0]       fifo_q [INV_FIFO_DEPTH];
  logic [31:0]       fifo_d [INV_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  entry_t            rd_a_q [WAYS];
  entry_t            rd_a_d [WAYS];
  entry_t            rd_b_q [WAYS];
  entry_t            rd_b_d [WAYS];

  logic [31:0]       head_addr;
  logic              full, inv_ready, push, pop;
  logic [WAYS-1:0]   hit_b, hit_a;
  logic [WAYS-1:0]   b_we;
  line_t             b_line, a_line;
  entry_t            b_wdata;
  logic              b_rd, a_we;

  assign head_addr = fifo_q[rd_ptr_q];
  assign full      = (count_q == (PTR_W+1)'(INV_FIFO_DEPTH));
  assign inv_ready = init_done_q && !full;
  assign push      = bus.inv_valid && inv_ready;
  assign pop       = (state_q == StInvWr) && !bus.update;
  assign a_line    = line_of(bus.stage1_addr);

  // Engine compare on the line it read in StInvRd.
  always_comb begin
    hit_b = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_b[w] = (rd_b_q[w][TAG_W:0] == {1'b1, tag_of(head_addr)});
    end
  end

  // Port B arbitration: sweep, then fill, then invalidation engine.
  always_comb begin
    b_we    = '0;
    b_rd    = 1'b0;
    b_line  = line_of(bus.stage2_addr);
    b_wdata = live_entry(tag_of(bus.stage2_addr));
    if (state_q == StInit) begin
      b_we    = '1;
      b_line  = sweep_q;
      b_wdata = '0;
    end else if (bus.update) begin
      b_we = bus.update_way;
    end else if (state_q == StInvRd) begin
      b_rd   = 1'b1;
      b_line = line_of(head_addr);
    end else if (state_q == StInvWr) begin
      b_we    = hit_b;
      b_line  = line_of(head_addr);
      b_wdata = '0;
    end
  end

  // A port-B write to the same line suppresses the whole stage-1 invalidate.
  assign a_we = bus.stage1_inv && (state_q != StInit) && !((|b_we) && (b_line == a_line));

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (a_we) tag_mem[w][a_line] <= '0;
      if (b_we[w]) tag_mem[w][b_line] <= b_wdata;
    end
  end

  // Registered reads see the array before this cycle's writes.
  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    for (int w = 0; w < WAYS; w++) begin
      if (bus.stage1_adv) rd_a_d[w] = tag_mem[w][a_line];
      if (b_rd) rd_b_d[w] = tag_mem[w][b_line];
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StInit: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == line_t'(LINES - 1)) state_d = StIdle;
      end
      StIdle:  if ((count_q != '0) && !bus.update) state_d = StInvRd;
      StInvRd: if (!bus.update) state_d = StInvWr;
      // A fill during the write slot may have changed the line, so read it again.
      StInvWr: state_d = bus.update ? StInvRd : StIdle;
      default: state_d = StInit;
    endcase
    init_done_d = (state_d != StInit);
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bus.inv_addr;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_q      <= '{default: '0};
      rd_a_q      <= '{default: '0};
      rd_b_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
    end
  end

  // Stage-2 compare on the held port-A data; forced to miss until the sweep completes.
`ifdef DTAG_PARITY_EN
  logic [WAYS-1:0] par_bad;
  always_comb begin
    hit_a   = '0;
    par_bad = '0;
    for (int w = 0; w < WAYS; w++) begin
      par_bad[w] = ^rd_a_q[w];
      hit_a[w]   = init_done_q && !par_bad[w]
                   && (rd_a_q[w][TAG_W:0] == {1'b1, tag_of(bus.stage2_addr)});
    end
  end
  assign bus.parity_err = init_done_q && (|par_bad);
`else
  always_comb begin
    hit_a = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_a[w] = init_done_q && (rd_a_q[w][TAG_W:0] == {1'b1, tag_of(bus.stage2_addr)});
    end
  end
`endif

  assign bus.tag_hit_way = hit_a;
  assign bus.tag_hit     = |hit_a;
  assign bus.inv_ready   = inv_ready;
  assign bus.init_done   = init_done_q;
  assign bus.inv_pending = (count_q != '0) || ((state_q != StIdle) && (state_q != StInit));

  // Only the line and tag fields of each address are meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.stage1_addr, bus.stage2_addr, bus.inv_addr, head_addr};

endmodule

// File: tb/tb_dtag_array.sv
module tb_dtag_array;
  localparam int unsigned WAYS  = 4;
  localparam int unsigned LINES = 64;
  localparam int unsigned TAG_W = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dtag_array_if #(.WAYS(WAYS)) bus ();

  dtag_array #(
    .WAYS           (WAYS),
    .LINES          (LINES),
    .TAG_W          (TAG_W),
    .SUB_LINE_ADDR_W(2),
    .INV_FIFO_DEPTH (4)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model of the array contents
  logic             mv [WAYS][LINES];
  logic [TAG_W-1:0] mt [WAYS][LINES];
  logic [WAYS-1:0]  exp_q [$];
  string            name_q [$];

  function automatic int unsigned l_of(input logic [31:0] a);
    return (a >> 4) & 32'h3f;
  endfunction

  function automatic logic [TAG_W-1:0] t_of(input logic [31:0] a);
    return TAG_W'(a >> 10);
  endfunction

  function automatic logic [WAYS-1:0] model_hit(input logic [31:0] a);
    logic [WAYS-1:0] r;
    r = '0;
    for (int w = 0; w < WAYS; w++) r[w] = mv[w][l_of(a)] && (mt[w][l_of(a)] == t_of(a));
    return r;
  endfunction

  task automatic model_clear_all();
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < LINES; l++) begin
        mv[w][l] = 1'b0;
        mt[w][l] = '0;
      end
  endtask

  task automatic model_inv(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (mv[w][l_of(a)] && mt[w][l_of(a)] == t_of(a)) mv[w][l_of(a)] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic compare_head();
    logic [WAYS-1:0] e;
    string nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    checks++;
    assert (bus.tag_hit_way === e && bus.tag_hit === (|e)) else begin
      errors++;
      $error("FAIL %s: observed way=%b hit=%b expected way=%b hit=%b",
             nm, bus.tag_hit_way, bus.tag_hit, e, |e);
    end
  endtask

  task automatic lookup(input logic [31:0] a, input string name);
    exp_q.push_back(model_hit(a));
    name_q.push_back(name);
    bus.stage1_addr = a;
    bus.stage1_adv  = 1'b1;
    @(posedge clk); #1;
    bus.stage1_adv  = 1'b0;
    bus.stage2_addr = a;
    #1;
    compare_head();
  endtask

  task automatic fill(input logic [31:0] a, input logic [WAYS-1:0] way);
    bus.update      = 1'b1;
    bus.update_way  = way;
    bus.stage2_addr = a;
    @(posedge clk); #1;
    bus.update = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (way[w]) begin
        mv[w][l_of(a)] = 1'b1;
        mt[w][l_of(a)] = t_of(a);
      end
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (bus.init_done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, LINES);
  endtask

  logic [31:0] a_list [5];
  logic [31:0] f_addr;
  int          n;

  initial begin
    bus.stage1_addr = '0;
    bus.stage1_adv  = 1'b0;
    bus.stage1_inv  = 1'b0;
    bus.stage2_addr = '0;
    bus.update      = 1'b0;
    bus.update_way  = '0;
    bus.inv_addr    = '0;
    bus.inv_valid   = 1'b0;
    model_clear_all();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_inv_ready", bus.inv_ready, 0);
    chk("rst_inv_pending", bus.inv_pending, 0);
    chk("rst_tag_hit", bus.tag_hit, 0);
    chk("rst_tag_hit_way", bus.tag_hit_way, 0);

    // Sweep length and cleared array
    rst_n = 1'b1;
    wait_init("sweep_cycles");
    chk("post_sweep_ready", bus.inv_ready, 1);
    chk("post_sweep_pending", bus.inv_pending, 0);
    for (int l = 0; l < LINES; l++) lookup(32'(l) << 4, "swept_line");

    // Fill and compare
    fill(32'h0001_2340, 4'b0010);
    lookup(32'h0001_2340, "fill_hit");
    chk("fill_way", bus.tag_hit_way, 4'b0010);
    lookup(32'h0001_2740, "fill_other_tag_miss");

    // Single external invalidation
    bus.inv_addr  = 32'h0001_2340;
    bus.inv_valid = 1'b1;
    #1;
    chk("inv_ready_idle", bus.inv_ready, 1);
    @(posedge clk); #1;
    bus.inv_valid = 1'b0;
    chk("inv_pending_set", bus.inv_pending, 1);
    n = 0;
    while (bus.inv_pending === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("inv_latency", n, 3);
    model_inv(32'h0001_2340);
    lookup(32'h0001_2340, "inv_miss");

    // Stage-1 invalidate alone, then colliding with a fill on line 0x0d
    fill(32'h0000_80d0, 4'b0001);
    lookup(32'h0000_80d0, "line0d_hit");
    bus.stage1_addr = 32'h0000_80d0;
    bus.stage1_inv  = 1'b1;
    @(posedge clk); #1;
    bus.stage1_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) mv[w][13] = 1'b0;
    lookup(32'h0000_80d0, "stage1_inv_miss");
    fill(32'h0000_80d0, 4'b0001);
    bus.stage1_addr = 32'h0000_80d0;
    bus.stage1_inv  = 1'b1;
    fill(32'h0000_80d0, 4'b0100);
    bus.stage1_inv = 1'b0;
    lookup(32'h0000_80d0, "collision_fill_wins");
    chk("collision_way", bus.tag_hit_way, 4'b0101);

    // Queue fills while a fill holds port B
    for (int k = 0; k < 5; k++) begin
      a_list[k] = ((32'h100 + 32'(k)) << 10) | ((32'(k) + 1) << 4);
      fill(a_list[k], 4'(1 << (k % 4)));
    end
    f_addr          = 32'h0000_ffc0;
    bus.update      = 1'b1;
    bus.update_way  = 4'b1000;
    bus.stage2_addr = f_addr;
    mv[3][l_of(f_addr)] = 1'b1;
    mt[3][l_of(f_addr)] = t_of(f_addr);
    for (int k = 0; k < 4; k++) begin
      bus.inv_addr  = a_list[k];
      bus.inv_valid = 1'b1;
      #1;
      chk("push_ready", bus.inv_ready, 1);
      @(posedge clk); #1;
    end
    bus.inv_addr = a_list[4];
    #1;
    chk("full_ready", bus.inv_ready, 0);
    @(posedge clk); #1;
    chk("stall_ready", bus.inv_ready, 0);
    chk("stall_pending", bus.inv_pending, 1);
    bus.update = 1'b0;
    n = 0;
    while (bus.inv_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_pop_cycles", n, 3);
    @(posedge clk); #1;
    bus.inv_valid = 1'b0;
    n = 0;
    while (bus.inv_pending === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_cycles", n, 11);
    for (int k = 0; k < 5; k++) model_inv(a_list[k]);
    for (int k = 0; k < 5; k++) lookup(a_list[k], "queued_inv_miss");
    lookup(f_addr, "held_fill_hit");

    // Reset while the engine is in its write slot
    bus.update      = 1'b1;
    bus.update_way  = 4'b1000;
    bus.stage2_addr = f_addr;
    for (int k = 0; k < 3; k++) begin
      bus.inv_addr  = ((32'h200 + 32'(k)) << 10) | ((32'd20 + 32'(k)) << 4);
      bus.inv_valid = 1'b1;
      #1;
      chk("rst_push_ready", bus.inv_ready, 1);
      @(posedge clk); #1;
    end
    bus.inv_valid = 1'b0;
    bus.update    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_hit", bus.tag_hit, 1);
    chk("pre_rst_pending", bus.inv_pending, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_init_done", bus.init_done, 0);
    chk("mid_rst_inv_ready", bus.inv_ready, 0);
    chk("mid_rst_inv_pending", bus.inv_pending, 0);
    chk("mid_rst_tag_hit", bus.tag_hit, 0);
    chk("mid_rst_tag_hit_way", bus.tag_hit_way, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("resweep_cycles");
    chk("resweep_pending", bus.inv_pending, 0);
    chk("resweep_ready", bus.inv_ready, 1);
    model_clear_all();
    lookup(f_addr, "resweep_fill_gone");
    lookup(32'h0000_80d0, "resweep_line0d_gone");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
